// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU result collector.
package alu_pkg;

  localparam int ARITH_W = 32;
  localparam int LOGIC_W = 16;
  localparam int SHIFT_W = 16;
  localparam int CMP_W   = 3;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_SHIFT = 2'd2,
    UNIT_CMP   = 2'd3
  } unit_e;

  typedef struct packed {
    logic [ARITH_W-1:0] data;
    logic               carry;
    unit_e              unit;
  } alu_res_t;

  localparam alu_res_t RES_ZERO = '{data: 32'h0000_0000, carry: 1'b0, unit: UNIT_ARITH};

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO of tagged ALU results with a registered head output.
// The head register is loaded with the entry that will be at the front after
// each edge, and holds its last value once the FIFO drains.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  alu_res_t               wdata,
  output alu_res_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

  alu_res_t         mem_q [DEPTH];
  alu_res_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] remain;
  alu_res_t         head_q, head_d;

  // Next state: storage write, pointer advance, occupancy and look-ahead head
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Entries still stored after this edge's pop, before counting the push
    remain  = level_q - LVL_W'(pop);
    level_d = remain + LVL_W'(push);

    if (level_d == LVL_ZERO) begin
      head_d = head_q;
    end else if (remain != LVL_ZERO) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = wdata;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: RES_ZERO};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= LVL_ZERO;
      head_q   <= RES_ZERO;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  assign rdata = head_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == LVL_ZERO);
  assign level = level_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU unit results into a FIFO, tags them with the producing unit,
// and counts dropped captures and multi-flag protocol errors.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [ARITH_W-1:0]     Arith_OUT,
  input  logic [LOGIC_W-1:0]     Logic_OUT,
  input  logic [SHIFT_W-1:0]     Shift_OUT,
  input  logic [CMP_W-1:0]       CMP_OUT,
  input  logic                   Carry_OUT,
  input  logic                   Arith_Flag,
  input  logic                   Logic_Flag,
  input  logic                   Shift_Flag,
  input  logic                   CMP_Flag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic                   res_carry,
  output logic [1:0]             res_unit,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   multi_flag_err,
  input  logic                   clr_err
);

  alu_res_t         cap_res;
  alu_res_t         head;
  logic             cap_any;
  logic             cap_multi;
  logic             pop_req;
  logic             push_ok;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             err_q, err_d;

  assign cap_any   = Arith_Flag | Logic_Flag | Shift_Flag | CMP_Flag;
  assign cap_multi = (Arith_Flag & (Logic_Flag | Shift_Flag | CMP_Flag)) |
                     (Logic_Flag & (Shift_Flag | CMP_Flag)) |
                     (Shift_Flag & CMP_Flag);

  // A full FIFO still accepts a push when the head leaves on the same edge
  assign pop_req = ~fifo_empty & res_ready;
  assign push_ok = cap_any & (~fifo_full | pop_req);
  assign drop    = cap_any & ~push_ok;

  // Fixed-priority unit selection and zero-extended packing of the capture
  always_comb begin
    cap_res = RES_ZERO;
    if (Arith_Flag) begin
      cap_res = '{data: Arith_OUT, carry: Carry_OUT, unit: UNIT_ARITH};
    end else if (Logic_Flag) begin
      cap_res = '{data: {{(ARITH_W-LOGIC_W){1'b0}}, Logic_OUT}, carry: 1'b0, unit: UNIT_LOGIC};
    end else if (Shift_Flag) begin
      cap_res = '{data: {{(ARITH_W-SHIFT_W){1'b0}}, Shift_OUT}, carry: 1'b0, unit: UNIT_SHIFT};
    end else if (CMP_Flag) begin
      cap_res = '{data: {{(ARITH_W-CMP_W){1'b0}}, CMP_OUT}, carry: 1'b0, unit: UNIT_CMP};
    end else begin
      cap_res = RES_ZERO;
    end
  end

  // Drop counter (saturating, clear wins) and sticky error (new event wins)
  always_comb begin
    if (clr_err) begin
      drop_cnt_d = {CNT_W{1'b0}};
    end else if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1'b1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (cap_multi) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Accounting registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_ok),
    .pop   (pop_req),
    .wdata (cap_res),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

  assign res_valid      = ~fifo_empty;
  assign res_data       = head.data;
  assign res_carry      = head.carry;
  assign res_unit       = head.unit;
  assign drop_cnt       = drop_cnt_q;
  assign multi_flag_err = err_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the collector.
module tb_alu_result_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic [15:0] Logic_OUT;
  logic [15:0] Shift_OUT;
  logic [2:0]  CMP_OUT;
  logic        Carry_OUT;
  logic        Arith_Flag, Logic_Flag, Shift_Flag, CMP_Flag;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_carry;
  logic [1:0]  res_unit;
  logic [3:0]  fill_level;
  logic [CNT_W-1:0] drop_cnt;
  logic        multi_flag_err;
  logic        clr_err;

  alu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .Shift_OUT(Shift_OUT),
    .CMP_OUT(CMP_OUT), .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .Shift_Flag(Shift_Flag), .CMP_Flag(CMP_Flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_unit(res_unit), .fill_level(fill_level),
    .drop_cnt(drop_cnt), .multi_flag_err(multi_flag_err), .clr_err(clr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic [1:0]  unit;
  } ent_t;

  ent_t mq[$];
  ent_t m_head;
  int   m_drop;
  logic m_err;
  int   checks = 0;
  int   errors = 0;
  int   maxfill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 1'b0; clr_err = 1'b0;
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; Shift_Flag = 1'b0; CMP_Flag = 1'b0;
  endtask

  // One clock: advance the reference model with the inputs seen at the edge,
  // then compare every output against it.
  task automatic tick();
    ent_t e;
    int   nf;
    bit   pop;
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_drop = 0;
      m_err  = 1'b0;
      m_head = '{32'h0, 1'b0, 2'd0};
    end else begin
      nf  = int'(Arith_Flag) + int'(Logic_Flag) + int'(Shift_Flag) + int'(CMP_Flag);
      pop = (mq.size() > 0) && res_ready;
      if (pop) void'(mq.pop_front());
      if (nf > 0) begin
        if (Arith_Flag)      e = '{Arith_OUT, Carry_OUT, 2'd0};
        else if (Logic_Flag) e = '{{16'h0, Logic_OUT}, 1'b0, 2'd1};
        else if (Shift_Flag) e = '{{16'h0, Shift_OUT}, 1'b0, 2'd2};
        else                 e = '{{29'h0, CMP_OUT}, 1'b0, 2'd3};
        if (mq.size() < DEPTH) mq.push_back(e);
        else if (m_drop < (1 << CNT_W) - 1) m_drop++;
      end
      if (clr_err) begin
        m_drop = 0;
        m_err  = 1'b0;
      end
      if (nf > 1) m_err = 1'b1;
      if (mq.size() > 0) m_head = mq[0];
    end
    #1;
    chk("valid", 32'(res_valid), 32'(mq.size() > 0));
    chk("fill",  32'(fill_level), 32'(mq.size()));
    chk("data",  res_data, m_head.data);
    chk("carry", 32'(res_carry), 32'(m_head.carry));
    chk("unit",  32'(res_unit), 32'(m_head.unit));
    chk("drop",  32'(drop_cnt), 32'(m_drop));
    chk("err",   32'(multi_flag_err), 32'(m_err));
  endtask

  task automatic cap_arith(input logic [31:0] d, input logic c);
    idle(); Arith_Flag = 1'b1; Arith_OUT = d; Carry_OUT = c;
  endtask

  initial begin
    Arith_OUT = 32'h0; Logic_OUT = 16'h0; Shift_OUT = 16'h0; CMP_OUT = 3'h0;
    Carry_OUT = 1'b0; res_ready = 1'b0;
    idle();
    RST = 1'b1;
    tick();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);

    // Single arith capture
    idle(); res_ready = 1'b1;
    cap_arith(32'h0001_FFFE, 1'b1);
    tick();
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_data", res_data, 32'h0001_FFFE);
    chk("t1_carry", 32'(res_carry), 32'd1);
    chk("t1_unit", 32'(res_unit), 32'd0);
    idle();
    tick();
    chk("t1_gone", 32'(res_valid), 32'd0);

    // Mixed stream under backpressure, then in-order drain
    res_ready = 1'b0;
    idle(); Logic_Flag = 1'b1; Logic_OUT = 16'hA5A5; tick();
    idle(); Shift_Flag = 1'b1; Shift_OUT = 16'h8000; tick();
    idle(); CMP_Flag = 1'b1; CMP_OUT = 3'b101; tick();
    cap_arith(32'h0000_1234, 1'b0); tick();
    idle(); tick(); tick();
    chk("t2_fill", 32'(fill_level), 32'd4);
    chk("t2_stall_data", res_data, 32'h0000_A5A5);
    chk("t2_stall_unit", 32'(res_unit), 32'd1);
    res_ready = 1'b1;
    tick(); chk("t2_d1", res_data, 32'h0000_8000); chk("t2_u1", 32'(res_unit), 32'd2);
    tick(); chk("t2_d2", res_data, 32'h0000_0005); chk("t2_u2", 32'(res_unit), 32'd3);
    tick(); chk("t2_d3", res_data, 32'h0000_1234); chk("t2_u3", 32'(res_unit), 32'd0);
    tick(); chk("t2_empty", 32'(res_valid), 32'd0); chk("t2_hold", res_data, 32'h0000_1234);

    // Overflow: 10 captures into 8 slots, then push+pop at full
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cap_arith(32'h100 + 32'(i), 1'b0);
      tick();
    end
    chk("t3_fill", 32'(fill_level), 32'd8);
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    chk("t3_head", res_data, 32'h100);
    res_ready = 1'b1;
    cap_arith(32'h200, 1'b1);
    tick();
    chk("t3_full_pp_fill", 32'(fill_level), 32'd8);
    chk("t3_full_pp_drop", 32'(drop_cnt), 32'd2);
    idle();
    for (int i = 0; i < 9; i++) tick();

    // Multi-flag error, then clear
    res_ready = 1'b0;
    idle(); Arith_Flag = 1'b1; Logic_Flag = 1'b1; Arith_OUT = 32'd7; Logic_OUT = 16'd9;
    tick();
    chk("t4_err", 32'(multi_flag_err), 32'd1);
    chk("t4_fill", 32'(fill_level), 32'd1);
    chk("t4_data", res_data, 32'd7);
    idle(); clr_err = 1'b1; tick();
    chk("t4_clr_err", 32'(multi_flag_err), 32'd0);
    chk("t4_clr_drop", 32'(drop_cnt), 32'd0);

    // Clear racing a drop, and clear racing a new multi-flag event
    for (int i = 0; i < 8; i++) begin
      cap_arith(32'h300 + 32'(i), 1'b0);
      tick();
    end
    cap_arith(32'h3FF, 1'b0); clr_err = 1'b1; tick();
    chk("t4_clr_vs_drop", 32'(drop_cnt), 32'd0);
    idle(); Shift_Flag = 1'b1; CMP_Flag = 1'b1; clr_err = 1'b1; tick();
    chk("t4_clr_vs_multi", 32'(multi_flag_err), 32'd1);

    // Reset mid-stream with a partly filled FIFO and a pending pop
    idle(); RST = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      cap_arith(32'h400 + 32'(i), 1'b1);
      tick();
    end
    idle(); res_ready = 1'b1; RST = 1'b1; tick();
    chk("t5_fill", 32'(fill_level), 32'd0);
    chk("t5_valid", 32'(res_valid), 32'd0);
    chk("t5_data", res_data, 32'd0);
    chk("t5_carry", 32'(res_carry), 32'd0);
    chk("t5_unit", 32'(res_unit), 32'd0);
    cap_arith(32'h0001_FFFE, 1'b1); tick();
    chk("t5_after", res_data, 32'h0001_FFFE);
    idle(); tick();

    // Wrap-around: 20 push/pop pairs with ready held high
    maxfill = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      case (i % 4)
        0: begin Arith_Flag = 1'b1; Arith_OUT = $urandom(); Carry_OUT = 1'($urandom()); end
        1: begin Logic_Flag = 1'b1; Logic_OUT = 16'($urandom()); end
        2: begin Shift_Flag = 1'b1; Shift_OUT = 16'($urandom()); end
        default: begin CMP_Flag = 1'b1; CMP_OUT = 3'($urandom()); end
      endcase
      tick();
      if (int'(fill_level) > maxfill) maxfill = int'(fill_level);
    end
    idle(); tick(); tick();
    chk("t6_maxfill", 32'(maxfill <= 2), 32'd1);
    chk("t6_drop", 32'(drop_cnt), 32'd0);

    // Random traffic: heavier backpressure first, lighter afterwards
    for (int i = 0; i < 400; i++) begin
      RST        = ($urandom_range(0, 99) == 0);
      clr_err    = ($urandom_range(0, 29) == 0);
      Arith_Flag = ($urandom_range(0, 3) == 0);
      Logic_Flag = ($urandom_range(0, 3) == 0);
      Shift_Flag = ($urandom_range(0, 3) == 0);
      CMP_Flag   = ($urandom_range(0, 3) == 0);
      Arith_OUT  = $urandom();
      Logic_OUT  = 16'($urandom());
      Shift_OUT  = 16'($urandom());
      CMP_OUT    = 3'($urandom());
      Carry_OUT  = 1'($urandom());
      res_ready  = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream consumer of the ALU output bundle (Arith/Logic/Shift/CMP results, Carry_OUT and the four unit flags).
- Each cycle in which any unit flag is high, it captures that unit's result, tags it with the unit ID, and pushes it into a small FIFO.
- A valid/ready port drains the FIFO toward the writeback/scoreboard side.
- Also provides overflow accounting and protocol-error detection for the ALU flag signals.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous reset, active-high
- Arith_OUT  in  32  arithmetic unit result
- Logic_OUT  in  16  logic unit result
- Shift_OUT  in  16  shift unit result
- CMP_OUT  in  3  compare unit result
- Carry_OUT  in  1  arithmetic carry
- Arith_Flag  in  1  arithmetic result valid this cycle
- Logic_Flag  in  1  logic result valid this cycle
- Shift_Flag  in  1  shift result valid this cycle
- CMP_Flag  in  1  compare result valid this cycle
- res_valid  out  1  FIFO head is valid
- res_ready  in  1  consumer accepts the head
- res_data  out  32  head result, zero-extended
- res_carry  out  1  head carry bit; 0 for non-arith entries
- res_unit  out  2  head unit tag: 0 arith, 1 logic, 2 shift, 3 cmp
- fill_level  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  CNT_W  number of dropped results, saturating
- multi_flag_err  out  1  sticky error: more than one flag seen in the same cycle
- clr_err  in  1  synchronous clear of drop_cnt and multi_flag_err

Behaviour:
- Reset: RST is synchronous and active-high on CLK. At reset, pointers and fill_level go to 0, res_valid=0, res_data=0, res_carry=0, res_unit=0, drop_cnt=0, multi_flag_err=0. Reset asserted mid-stream discards all entries, with no partial pop.
- Capture selection: a capture occurs when any flag is high, with fixed priority Arith > Logic > Shift > CMP.
- Entry packing:
  - Arith: data=Arith_OUT, carry=Carry_OUT.
  - Logic/Shift: data={16'b0, X_OUT}, carry=0.
  - CMP: data={29'b0, CMP_OUT}, carry=0.
- Multiple flags: if two or more flags are high in one cycle, only the highest-priority unit is pushed and multi_flag_err sets the next cycle. It stays set until clr_err or RST.
- Handshake:
  - Pop occurs when res_valid && res_ready.
  - res_data, res_carry and res_unit are driven from the head entry and must be stable while res_valid=1 and res_ready=0.
  - When res_valid=0, these outputs hold their last values.
- Latency: a push into an empty FIFO makes res_valid=1 in the cycle after the capture edge. There is no same-cycle bypass.
- Full FIFO:
  - A push is accepted if fill_level<DEPTH, or if a pop occurs in the same cycle (simultaneous push+pop at full is legal and leaves fill_level=DEPTH).
  - Otherwise the capture is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- Empty FIFO: res_valid=0; res_ready is ignored.
- Simultaneous push+pop when not empty: fill_level is unchanged and the order is preserved (FIFO).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_level is tracked as an explicit counter.
- clr_err with a drop in the same cycle: the clear wins, so drop_cnt=0.
- clr_err with a new multi-flag event in the same cycle: the error sets, so multi_flag_err=1.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic[1:0] unit_e {UNIT_ARITH, UNIT_LOGIC, UNIT_SHIFT, UNIT_CMP};
  - packed struct alu_res_t {data[31:0], carry, unit_e unit};
  - localparams for result widths (16/32/3).
- Sub-module: alu_res_fifo, a generic synchronous FIFO over alu_res_t with push/pop/full/empty/level. The top level handles priority selection, packing, counters and error flags.

Test Plan:
1. Single arith capture: Arith_Flag=1, Arith_OUT=32'h0001_FFFE, Carry_OUT=1, res_ready=1 -> the next cycle shows res_valid=1, res_data=32'h0001_FFFE, res_carry=1, res_unit=0; the cycle after, res_valid=0.
2. Mixed stream with backpressure: 4 captures, logic 16'hA5A5 / shift 16'h8000 / cmp 3'b101 / arith 32'h1234, with res_ready=0 -> fill_level=4. Then res_ready=1 -> outputs drain in order: 32'h0000A5A5 u1, 32'h00008000 u2, 32'h5 u3, 32'h1234 u0. Head outputs stay stable while stalled.
3. Overflow, DEPTH=8: 10 consecutive captures with res_ready=0 -> fill_level=8, drop_cnt=2, and the first 8 entries are retained. Then a capture with res_ready=1 at full -> accepted, drop_cnt stays 2.
4. Multi-flag: Arith_Flag=Logic_Flag=1, Arith_OUT=7, Logic_OUT=9 -> one entry pushed (data 7, unit 0) and multi_flag_err=1. Then clr_err pulse -> multi_flag_err=0 and drop_cnt=0.
5. Reset mid-operation: FIFO holding 5 entries, assert RST for 1 cycle -> next cycle fill_level=0, res_valid=0, all outputs 0. A following capture behaves as in test 1.
6. Wrap-around: 20 push/pop pairs, each with res_ready=1 -> all 20 entries are returned in order, fill_level never exceeds 2, drop_cnt=0.
